// File: rtl/calc_keypad_encoder.sv
// calc_keypad_encoder
//   Scans a 4x4 active-low matrix keypad, debounces a press, emits one
//   command code per physical press for HOLD cycles, then waits for a
//   debounced release and a short idle gap before scanning again.
//
// Ports
//   clock     : system clock, everything updates on the rising edge
//   reset     : asynchronous active-high reset
//   cols_in   : keypad columns, active-low (external pull-ups)
//   rows_out  : row drive, active-low, exactly one bit low
//   cmd       : command code, 4'b1111 = idle
//   cmd_valid : high while cmd carries a non-idle code
//   busy      : high in every state except SCAN
module calc_keypad_encoder #(
  parameter int SCAN_DIV = 4,   // cycles per row, >= 3 (covers synchronizer latency)
  parameter int DEBOUNCE = 8,   // stable cycles to accept press / release
  parameter int HOLD     = 10,  // cycles a code is held on cmd
  parameter int GAP      = 2    // idle cycles after release
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols_in,
  output logic [3:0] rows_out,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       busy
);

  localparam int CMAX_A = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int CMAX   = (CMAX_A > GAP) ? CMAX_A : GAP;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int DW     = $clog2(SCAN_DIV);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_EMIT,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t        state;
  logic [3:0]    sync1, cols_s;
  logic [1:0]    row;       // current (or latched) row index
  logic [1:0]    key_col;   // latched column of the detected key
  logic [3:0]    cols_ref;  // column pattern sampled when the key was latched
  logic [DW-1:0] dwell;
  logic [CW-1:0] cnt;

  // Active-low drive pattern for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest-index low column wins when several columns are low.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'b0001;
      4'h1: return 4'b0010;
      4'h2: return 4'b0011;
      4'h3: return 4'b1010;  // add
      4'h4: return 4'b0100;
      4'h5: return 4'b0101;
      4'h6: return 4'b0110;
      4'h7: return 4'b1011;  // sub
      4'h8: return 4'b0111;
      4'h9: return 4'b1000;
      4'hA: return 4'b1001;
      4'hB: return 4'b1100;  // mul
      4'hC: return 4'b1101;  // clear
      4'hD: return 4'b0000;
      4'hE: return 4'b1110;  // equals
      default: return 4'b1111;  // reserved
    endcase
  endfunction

  wire reserved = (row == 2'd3) && (key_col == 2'd3);

  // Two-flop synchronizer; idle (all high) out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 4'b1111;
      cols_s <= 4'b1111;
    end else begin
      sync1  <= cols_in;
      cols_s <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_SCAN;
      row       <= 2'd0;
      key_col   <= 2'd0;
      cols_ref  <= 4'b1111;
      dwell     <= '0;
      cnt       <= '0;
      rows_out  <= 4'b1110;
      cmd       <= 4'b1111;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (cols_s != 4'b1111) begin
              // Keep this row driven; remember the pattern to debounce against.
              state    <= S_DEBOUNCE;
              key_col  <= low_col(cols_s);
              cols_ref <= cols_s;
              cnt      <= '0;
              busy     <= 1'b1;
            end else begin
              row      <= row + 2'd1;
              rows_out <= row_drive(row + 2'd1);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        S_DEBOUNCE: begin
          if (cols_s != cols_ref) begin
            // Bounce: abandon silently and carry on scanning past this row.
            state    <= S_SCAN;
            row      <= row + 2'd1;
            rows_out <= row_drive(row + 2'd1);
            dwell    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
          end else if (cnt == DB_LAST) begin
            cnt <= '0;
            if (reserved) begin
              state <= S_RELEASE;
            end else begin
              state     <= S_EMIT;
              cmd       <= key_code(row, key_col);
              cmd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_EMIT: begin
          // cmd is frozen here; column activity is ignored.
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            state     <= S_RELEASE;
            cmd       <= 4'b1111;
            cmd_valid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if (cols_s != 4'b1111) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt <= '0;
            if (GAP == 0) begin
              state    <= S_SCAN;
              row      <= 2'd0;
              rows_out <= 4'b1110;
              dwell    <= '0;
              busy     <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            state    <= S_SCAN;
            row      <= 2'd0;
            rows_out <= 4'b1110;
            dwell    <= '0;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= S_SCAN;
          row       <= 2'd0;
          rows_out  <= 4'b1110;
          dwell     <= '0;
          cnt       <= '0;
          cmd       <= 4'b1111;
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
